// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, N entries of WIDTH bits, registered read data.
// N does not have to be a power of two; both pointers wrap explicitly at N-1.
// Optional macro SYNC_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
`ifdef SYNC_FIFO_ERR_EN
  output logic             empty,
  output logic             overflow,
  output logic             underflow
`else
  output logic             empty
`endif
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [WIDTH-1:0] mem [N];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             wr_acc;
  logic             rd_acc;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;
`endif

  // Status flags come straight from the occupancy register
  assign full  = (count_q == CNT_W'(N));
  assign empty = (count_q == '0);
  assign dout  = dout_q;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  // Next-state for pointers, count, read data and error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(N - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(N - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      dout_d   = mem[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

`ifdef SYNC_FIFO_ERR_EN
    overflow_d  = overflow_q  | (wr_en && full && !rd_en);
    underflow_d = underflow_q | (rd_en && empty);
`endif
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; contents survive reset and are written only on an accepted write
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo with N=9, WIDTH=8.
// Build with SYNC_FIFO_ERR_EN defined to also check overflow/underflow.
module tb_sync_fifo;

  localparam int unsigned N     = 9;
  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
`ifdef SYNC_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  int n_cmp;
  int n_err;

  sync_fifo #(.N(N), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .dout     (dout),
    .full     (full),
`ifdef SYNC_FIFO_ERR_EN
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty    (empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs settle 1 time unit after the edge
  task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #2;

    // Reset state
    do_reset();
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full",  32'(full),  32'd0);
    check_eq("rst_dout",  32'(dout),  32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("rst_ovf", 32'(overflow),  32'd0);
    check_eq("rst_unf", 32'(underflow), 32'd0);
`endif

    // Fill with 0..8
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b0, WIDTH'(i));
      check_eq("fill_full",  32'(full),  (i == 8) ? 32'd1 : 32'd0);
      check_eq("fill_empty", 32'(empty), 32'd0);
    end
`ifdef SYNC_FIFO_ERR_EN
    check_eq("fill_ovf", 32'(overflow), 32'd0);
`endif

    // Dropped write while full
    step(1'b0, 1'b1, 1'b0, 8'd9);
    check_eq("drop_full", 32'(full), 32'd1);
    check_eq("drop_dout", 32'(dout), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("drop_ovf", 32'(overflow), 32'd1);
`endif

    // Drain: 0..8 in order, dropped 9 never appears
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check_eq("drain_dout",  32'(dout),  32'(i));
      check_eq("drain_full",  32'(full),  32'd0);
      check_eq("drain_empty", 32'(empty), (i == 8) ? 32'd1 : 32'd0);
    end
`ifdef SYNC_FIFO_ERR_EN
    check_eq("drain_unf", 32'(underflow), 32'd0);
`endif

    // Read while empty is ignored
    step(1'b0, 1'b0, 1'b1, '0);
    check_eq("uread_dout",  32'(dout),  32'd8);
    check_eq("uread_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("uread_unf", 32'(underflow), 32'd1);
`endif

    // rd_en held high: each word shows up one edge after it was written
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, WIDTH'(i));
      check_eq("pass_dout",  32'(dout),  (i == 0) ? 32'd8 : 32'(i - 1));
      check_eq("pass_empty", 32'(empty), 32'd0);
      check_eq("pass_full",  32'(full),  32'd0);
    end
    step(1'b0, 1'b0, 1'b1, '0);
    check_eq("pass_last",  32'(dout),  32'd9);
    check_eq("pass_empty_end", 32'(empty), 32'd1);

    // Wrap: offset pointers by 5, then fill and drain across the wrap point
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check_eq("wrap_pre_dout", 32'(dout), 32'(i));
    end
    check_eq("wrap_pre_empty", 32'(empty), 32'd1);
    for (int i = 10; i < 19; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
    check_eq("wrap_full", 32'(full), 32'd1);
    for (int i = 10; i < 19; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check_eq("wrap_dout", 32'(dout), 32'(i));
    end
    check_eq("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous read and write while full
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
    step(1'b0, 1'b1, 1'b1, 8'd99);
    check_eq("fullrw_dout", 32'(dout), 32'd0);
    check_eq("fullrw_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("fullrw_ovf", 32'(overflow), 32'd0);
`endif
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check_eq("fullrw_drain", 32'(dout), (i == 9) ? 32'd99 : 32'(i));
    end
    check_eq("fullrw_empty", 32'(empty), 32'd1);

    // Simultaneous read and write while empty: only the write lands
    step(1'b0, 1'b1, 1'b1, 8'd55);
    check_eq("emptyrw_dout",  32'(dout),  32'd99);
    check_eq("emptyrw_empty", 32'(empty), 32'd0);
    check_eq("emptyrw_full",  32'(full),  32'd0);
    step(1'b0, 1'b0, 1'b1, '0);
    check_eq("emptyrw_read",  32'(dout),  32'd55);
    check_eq("emptyrw_empty2", 32'(empty), 32'd1);

    // Reset with data stored overrides a concurrent write
    for (int i = 1; i < 5; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
    check_eq("pre_rst_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'd77);
    rst = 1'b0;
    check_eq("midrst_empty", 32'(empty), 32'd1);
    check_eq("midrst_full",  32'(full),  32'd0);
    check_eq("midrst_dout",  32'(dout),  32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("midrst_unf", 32'(underflow), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b1, '0);
    check_eq("postrst_dout",  32'(dout),  32'd0);
    check_eq("postrst_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
